// File: rtl/ttt_network_pkg.sv
// Shared definitions for the token fan-out network.
//   instr_e  : 3-bit programming instruction codes (5..7 are not listed and do nothing)
//   state_e  : fan-out sequencer states
//   chan_width() : width of a channel index, never less than one bit
package ttt_network_pkg;

  typedef enum logic [2:0] {
    INSTR_NOP        = 3'd0,
    INSTR_SET_START  = 3'd1,
    INSTR_SET_END    = 3'd2,
    INSTR_SET_TARGET = 3'd3,
    INSTR_SET_TOKENS = 3'd4
  } instr_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic int chan_width(input int num_channels);
    int w;
    w = $clog2(num_channels);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

endpackage

// File: rtl/ttt_connection_table.sv
// Connection table storage for the fan-out network.
//   clk, reset      : clock, asynchronous active-low clear of every entry
//   wr_*            : single write port (instruction decode happens here)
//   rd_proc         : processor read address -> rd_start_ptr, rd_end_ptr, rd_proc_ok
//   rd_conn         : connection read address -> rd_target, rd_tokens (0 when out of range)
// Writes whose index does not name an existing entry match no entry and are dropped.
module ttt_connection_table
  import ttt_network_pkg::*;
#(
  parameter int NUM_PROCESSORS  = 16,
  parameter int NUM_CONNECTIONS = 64,
  parameter int NEW_TOKEN_BITS  = 4,
  parameter int NUM_CHANNELS    = 2,
  localparam int PW = $clog2(NUM_PROCESSORS),
  localparam int CW = $clog2(NUM_CONNECTIONS + 32'sd1),
  localparam int HW = chan_width(NUM_CHANNELS),
  localparam int TW = NUM_CHANNELS * NEW_TOKEN_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [2:0]                wr_instr,
  input  logic [PW-1:0]             wr_proc,
  input  logic [CW-1:0]             wr_conn,
  input  logic [HW-1:0]             wr_chan,
  input  logic [NEW_TOKEN_BITS-1:0] wr_tokens,
  input  logic [PW-1:0]             rd_proc,
  output logic [CW-1:0]             rd_start_ptr,
  output logic [CW-1:0]             rd_end_ptr,
  output logic                      rd_proc_ok,
  input  logic [CW-1:0]             rd_conn,
  output logic [PW-1:0]             rd_target,
  output logic [TW-1:0]             rd_tokens
);

  logic [CW-1:0] start_ptr_q [NUM_PROCESSORS];
  logic [CW-1:0] start_ptr_d [NUM_PROCESSORS];
  logic [CW-1:0] end_ptr_q   [NUM_PROCESSORS];
  logic [CW-1:0] end_ptr_d   [NUM_PROCESSORS];
  logic [PW-1:0] target_q    [NUM_CONNECTIONS];
  logic [PW-1:0] target_d    [NUM_CONNECTIONS];
  logic [TW-1:0] tokens_q    [NUM_CONNECTIONS];
  logic [TW-1:0] tokens_d    [NUM_CONNECTIONS];

  logic wr_start_s;
  logic wr_end_s;
  logic wr_target_s;
  logic wr_tokens_s;

  assign wr_start_s  = wr_en && (wr_instr == INSTR_SET_START);
  assign wr_end_s    = wr_en && (wr_instr == INSTR_SET_END);
  assign wr_target_s = wr_en && (wr_instr == INSTR_SET_TARGET);
  assign wr_tokens_s = wr_en && (wr_instr == INSTR_SET_TOKENS);

  // Next table contents: full-width index compare so out-of-range indices never alias
  always_comb begin
    for (int p = 0; p < NUM_PROCESSORS; p++) begin
      start_ptr_d[p] = (wr_start_s && (wr_proc == PW'(p))) ? wr_conn : start_ptr_q[p];
      end_ptr_d[p]   = (wr_end_s   && (wr_proc == PW'(p))) ? wr_conn : end_ptr_q[p];
    end
    for (int c = 0; c < NUM_CONNECTIONS; c++) begin
      target_d[c] = (wr_target_s && (wr_conn == CW'(c))) ? wr_proc : target_q[c];
      tokens_d[c] = tokens_q[c];
      for (int h = 0; h < NUM_CHANNELS; h++) begin
        tokens_d[c][h*NEW_TOKEN_BITS +: NEW_TOKEN_BITS] =
          (wr_tokens_s && (wr_conn == CW'(c)) && (wr_chan == HW'(h))) ?
          wr_tokens : tokens_q[c][h*NEW_TOKEN_BITS +: NEW_TOKEN_BITS];
      end
    end
  end

  // Processor read port (kept separate from the connection port to avoid a block-level loop)
  always_comb begin
    rd_start_ptr = {CW{1'b0}};
    rd_end_ptr   = {CW{1'b0}};
    rd_proc_ok   = 1'b0;
    for (int p = 0; p < NUM_PROCESSORS; p++) begin
      rd_start_ptr = (rd_proc == PW'(p)) ? start_ptr_q[p] : rd_start_ptr;
      rd_end_ptr   = (rd_proc == PW'(p)) ? end_ptr_q[p]   : rd_end_ptr;
      rd_proc_ok   = rd_proc_ok | (rd_proc == PW'(p));
    end
  end

  // Connection read port
  always_comb begin
    rd_target = {PW{1'b0}};
    rd_tokens = {TW{1'b0}};
    for (int c = 0; c < NUM_CONNECTIONS; c++) begin
      rd_target = (rd_conn == CW'(c)) ? target_q[c] : rd_target;
      rd_tokens = (rd_conn == CW'(c)) ? tokens_q[c] : rd_tokens;
    end
  end

  // Table registers, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PROCESSORS; p++) begin
        start_ptr_q[p] <= {CW{1'b0}};
        end_ptr_q[p]   <= {CW{1'b0}};
      end
      for (int c = 0; c < NUM_CONNECTIONS; c++) begin
        target_q[c] <= {PW{1'b0}};
        tokens_q[c] <= {TW{1'b0}};
      end
    end else begin
      start_ptr_q <= start_ptr_d;
      end_ptr_q   <= end_ptr_d;
      target_q    <= target_d;
      tokens_q    <= tokens_d;
    end
  end

endmodule

// File: rtl/ttt_fanout_network.sv
// Token fan-out sequencer: on start, walks connection entries [start_ptr, end_ptr)
// of processor_id and presents one beat per entry on a valid/ready interface.
//   clk, reset (async active-low)
//   start, processor_id        : fan-out request, sampled in IDLE
//   busy, done                 : status; done pulses once per fan-out (also when empty)
//   valid, ready, target_id, new_tokens, last : beat interface, all registered
//   prog_valid, instruction, prog_processor, prog_connection, prog_channel, prog_tokens
//                              : table programming, honoured only in IDLE
module ttt_fanout_network
  import ttt_network_pkg::*;
#(
  parameter int NUM_PROCESSORS  = 16,
  parameter int NUM_CONNECTIONS = 64,
  parameter int NEW_TOKEN_BITS  = 4,
  parameter int NUM_CHANNELS    = 2,
  localparam int PW = $clog2(NUM_PROCESSORS),
  localparam int CW = $clog2(NUM_CONNECTIONS + 32'sd1),
  localparam int HW = chan_width(NUM_CHANNELS),
  localparam int TW = NUM_CHANNELS * NEW_TOKEN_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [PW-1:0]             processor_id,
  output logic                      busy,
  output logic                      valid,
  input  logic                      ready,
  output logic [PW-1:0]             target_id,
  output logic [TW-1:0]             new_tokens,
  output logic                      last,
  output logic                      done,
  input  logic                      prog_valid,
  input  logic [2:0]                instruction,
  input  logic [PW-1:0]             prog_processor,
  input  logic [CW-1:0]             prog_connection,
  input  logic [HW-1:0]             prog_channel,
  input  logic [NEW_TOKEN_BITS-1:0] prog_tokens
);

  localparam logic [CW-1:0] PTR_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] end_q, end_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [PW-1:0] target_id_q, target_id_d;
  logic [TW-1:0] new_tokens_q, new_tokens_d;

  logic [CW-1:0] rd_start_ptr, rd_end_ptr, rd_conn_s, ptr_next_s;
  logic          rd_proc_ok;
  logic [PW-1:0] rd_target;
  logic [TW-1:0] rd_tokens;
  logic          wr_en_s;

  assign wr_en_s    = prog_valid && (state_q == ST_IDLE);
  assign ptr_next_s = ptr_q + PTR_ONE;

  ttt_connection_table #(
    .NUM_PROCESSORS (NUM_PROCESSORS),
    .NUM_CONNECTIONS(NUM_CONNECTIONS),
    .NEW_TOKEN_BITS (NEW_TOKEN_BITS),
    .NUM_CHANNELS   (NUM_CHANNELS)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en_s),
    .wr_instr    (instruction),
    .wr_proc     (prog_processor),
    .wr_conn     (prog_connection),
    .wr_chan     (prog_channel),
    .wr_tokens   (prog_tokens),
    .rd_proc     (processor_id),
    .rd_start_ptr(rd_start_ptr),
    .rd_end_ptr  (rd_end_ptr),
    .rd_proc_ok  (rd_proc_ok),
    .rd_conn     (rd_conn_s),
    .rd_target   (rd_target),
    .rd_tokens   (rd_tokens)
  );

  // Connection read address looks ahead to the entry the next registered beat will carry
  always_comb begin
    if (state_q == ST_IDLE) begin
      rd_conn_s = rd_start_ptr;
    end else if ((state_q == ST_EMIT) && ready) begin
      rd_conn_s = ptr_next_s;
    end else begin
      rd_conn_s = ptr_q;
    end
  end

  // Sequencer next state and next registered outputs
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    end_d        = end_q;
    busy_d       = busy_q;
    valid_d      = 1'b0;
    last_d       = 1'b0;
    done_d       = 1'b0;
    target_id_d  = {PW{1'b0}};
    new_tokens_d = {TW{1'b0}};
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        // Programming wins over a coincident start
        if (start && !prog_valid) begin
          ptr_d  = rd_start_ptr;
          end_d  = rd_end_ptr;
          busy_d = 1'b1;
          if (!rd_proc_ok || (rd_start_ptr >= rd_end_ptr)) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d      = ST_EMIT;
            valid_d      = 1'b1;
            target_id_d  = rd_target;
            new_tokens_d = rd_tokens;
            last_d       = ((rd_start_ptr + PTR_ONE) == rd_end_ptr);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (ready) begin
          ptr_d = ptr_next_s;
          if (last_q) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            valid_d      = 1'b1;
            target_id_d  = rd_target;
            new_tokens_d = rd_tokens;
            last_d       = ((ptr_next_s + PTR_ONE) == end_q);
          end
        end else begin
          valid_d      = valid_q;
          last_d       = last_q;
          target_id_d  = target_id_q;
          new_tokens_d = new_tokens_q;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= {CW{1'b0}};
      end_q        <= {CW{1'b0}};
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      done_q       <= 1'b0;
      target_id_q  <= {PW{1'b0}};
      new_tokens_q <= {TW{1'b0}};
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      end_q        <= end_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      last_q       <= last_d;
      done_q       <= done_d;
      target_id_q  <= target_id_d;
      new_tokens_q <= new_tokens_d;
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign last       = last_q;
  assign done       = done_q;
  assign target_id  = target_id_q;
  assign new_tokens = new_tokens_q;

endmodule

// File: tb/tb_ttt_fanout_network.sv
// Scoreboard bench for ttt_fanout_network (default parameters: PW=4, CW=7, HW=1, 8-bit tokens).
// Stimulus pushes expected beats/done events into exp_q; the negedge monitor pops and compares.
module tb_ttt_fanout_network;

  logic       clk = 1'b0;
  logic       reset, start, ready, prog_valid, prog_channel;
  logic [3:0] processor_id, prog_processor, prog_tokens, target_id;
  logic [2:0] instruction;
  logic [6:0] prog_connection;
  logic       busy, valid, last, done;
  logic [7:0] new_tokens;

  int n_checks  = 0;
  int n_errors  = 0;
  int zero_viol = 0;

  typedef struct packed {
    logic       is_done;
    logic [3:0] tgt;
    logic [7:0] tok;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_m, exp_m;

  localparam exp_t DONE_E = {1'b1, 4'd0, 8'd0, 1'b0};

  always #5 clk = ~clk;

  ttt_fanout_network dut (
    .clk(clk), .reset(reset), .start(start), .processor_id(processor_id),
    .busy(busy), .valid(valid), .ready(ready), .target_id(target_id),
    .new_tokens(new_tokens), .last(last), .done(done),
    .prog_valid(prog_valid), .instruction(instruction), .prog_processor(prog_processor),
    .prog_connection(prog_connection), .prog_channel(prog_channel), .prog_tokens(prog_tokens)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t beat(input logic [3:0] t, input logic [7:0] k, input logic l);
    return {1'b0, t, k, l};
  endfunction

  // Monitor: every accepted beat or done pulse must match the head of the queue
  always @(negedge clk) begin
    if (reset && ((valid && ready) || done)) begin
      got_m = {done, target_id, new_tokens, last};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard: unexpected output %h with empty queue", got_m);
      end else begin
        exp_m = exp_q.pop_front();
        check("scoreboard", 32'(got_m), 32'(exp_m));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1
  task automatic prog(input logic [2:0] ins, input logic [3:0] p, input logic [6:0] c,
                      input logic ch, input logic [3:0] t);
    prog_valid = 1'b1; instruction = ins; prog_processor = p;
    prog_connection = c; prog_channel = ch; prog_tokens = t;
    @(posedge clk); #1;
    prog_valid = 1'b0;
  endtask

  task automatic prog_p3();
    prog(3'd1, 4'd3, 7'd4, 1'b0, 4'h0);
    prog(3'd2, 4'd3, 7'd7, 1'b0, 4'h0);
    prog(3'd3, 4'd1, 7'd4, 1'b0, 4'h0);
    prog(3'd3, 4'd2, 7'd5, 1'b0, 4'h0);
    prog(3'd3, 4'd9, 7'd6, 1'b0, 4'h0);
    prog(3'd4, 4'd0, 7'd4, 1'b0, 4'h2);
    prog(3'd4, 4'd0, 7'd4, 1'b1, 4'hF);
    prog(3'd4, 4'd0, 7'd5, 1'b0, 4'h0);
    prog(3'd4, 4'd0, 7'd5, 1'b1, 4'h3);
    prog(3'd4, 4'd0, 7'd6, 1'b0, 4'h8);
    prog(3'd4, 4'd0, 7'd6, 1'b1, 4'h7);
  endtask

  task automatic push_p3();
    exp_q.push_back(beat(4'd1, 8'hF2, 1'b0));
    exp_q.push_back(beat(4'd2, 8'h30, 1'b0));
    exp_q.push_back(beat(4'd9, 8'h78, 1'b1));
    exp_q.push_back(DONE_E);
  endtask

  // Issue start and observe until done; k counts negedges after the start edge
  task automatic run_fanout(input logic [3:0] pid, input int stall_at, input int stall_len,
                            input bit inject, input int max_k,
                            output int vcnt, output int done_k, output int first_v,
                            output int hold_cnt, output logic busy_k1);
    vcnt = 0; done_k = 0; first_v = 0; hold_cnt = 0; busy_k1 = 1'b0;
    processor_id = pid;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      ready = !((k >= stall_at) && (k < stall_at + stall_len));
      if (inject && (k == 1)) begin
        prog_valid = 1'b1; instruction = 3'd3; prog_connection = 7'd5;
        prog_processor = 4'd13; start = 1'b1; processor_id = 4'd0;
      end else begin
        prog_valid = 1'b0; start = 1'b0;
      end
      @(negedge clk);
      if (k == 1) busy_k1 = busy;
      if (valid) begin
        vcnt++;
        if (first_v == 0) first_v = k;
        if (target_id == 4'd2 && new_tokens == 8'h30) hold_cnt++;
      end else if (target_id != 4'd0 || new_tokens != 8'd0 || last != 1'b0) begin
        zero_viol++;
      end
      if (done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    prog_valid = 1'b0; start = 1'b0; ready = 1'b1;
    if (done_k == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL timeout: no done within %0d cycles for processor %0d", max_k, pid);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_check(input string name);
    @(negedge clk);
    check(name, {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  int   vc, dk, fv, hc;
  logic bk;

  initial begin
    reset = 1'b0; start = 1'b0; ready = 1'b1; prog_valid = 1'b0; processor_id = 4'd0;
    instruction = 3'd0; prog_processor = 4'd0; prog_connection = 7'd0;
    prog_channel = 1'b0; prog_tokens = 4'd0;
    #1;
    check("reset_outputs", {16'd0, busy, valid, last, done, target_id, new_tokens}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", {16'd0, busy, valid, last, done, target_id, new_tokens}, 32'd0);
    @(posedge clk); #1;

    // Basic three-beat fan-out
    prog_p3();
    push_p3();
    run_fanout(4'd3, 0, 0, 1'b0, 20, vc, dk, fv, hc, bk);
    check("t1_beat_cycles", 32'(vc), 32'd3);
    check("t1_first_valid", 32'(fv), 32'd1);
    check("t1_done_cycle", 32'(dk), 32'd4);
    check("t1_busy", {31'd0, bk}, 32'd1);
    idle_check("t1_busy_after");

    // Back-pressure on beat 2 for two cycles
    push_p3();
    run_fanout(4'd3, 2, 2, 1'b0, 20, vc, dk, fv, hc, bk);
    check("t2_beat_cycles", 32'(vc), 32'd5);
    check("t2_hold_cycles", 32'(hc), 32'd3);
    check("t2_done_cycle", 32'(dk), 32'd6);

    // Empty ranges: start==end and start>end
    prog(3'd1, 4'd5, 7'd10, 1'b0, 4'h0);
    prog(3'd2, 4'd5, 7'd10, 1'b0, 4'h0);
    prog(3'd1, 4'd6, 7'd12, 1'b0, 4'h0);
    prog(3'd2, 4'd6, 7'd8,  1'b0, 4'h0);
    exp_q.push_back(DONE_E);
    run_fanout(4'd5, 0, 0, 1'b0, 10, vc, dk, fv, hc, bk);
    check("t3_p5_beats", 32'(vc), 32'd0);
    check("t3_p5_done", 32'(dk), 32'd1);
    exp_q.push_back(DONE_E);
    run_fanout(4'd6, 0, 0, 1'b0, 10, vc, dk, fv, hc, bk);
    check("t3_p6_beats", 32'(vc), 32'd0);
    check("t3_p6_done", 32'(dk), 32'd1);

    // Final table entry with end pointer equal to the table size
    prog(3'd1, 4'd0, 7'd63, 1'b0, 4'h0);
    prog(3'd2, 4'd0, 7'd64, 1'b0, 4'h0);
    prog(3'd3, 4'd5, 7'd63, 1'b0, 4'h0);
    prog(3'd4, 4'd0, 7'd63, 1'b0, 4'h1);
    prog(3'd4, 4'd0, 7'd63, 1'b1, 4'hE);
    exp_q.push_back(beat(4'd5, 8'hE1, 1'b1));
    exp_q.push_back(DONE_E);
    run_fanout(4'd0, 0, 0, 1'b0, 10, vc, dk, fv, hc, bk);
    check("t4_beats", 32'(vc), 32'd1);
    check("t4_done", 32'(dk), 32'd2);

    // Programming and start during EMIT are ignored
    push_p3();
    run_fanout(4'd3, 0, 0, 1'b1, 20, vc, dk, fv, hc, bk);
    check("t5_done", 32'(dk), 32'd4);
    idle_check("t5_no_restart");
    push_p3();
    run_fanout(4'd3, 0, 0, 1'b0, 20, vc, dk, fv, hc, bk);
    check("t5_rerun_beats", 32'(vc), 32'd3);

    // Reset in the middle of a fan-out
    exp_q.push_back(beat(4'd1, 8'hF2, 1'b0));
    processor_id = 4'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    check("t6_beat2_present", {31'd0, valid}, 32'd1);
    reset = 1'b0;
    #1;
    check("t6_reset_immediate", {16'd0, busy, valid, last, done, target_id, new_tokens}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.push_back(DONE_E);
    run_fanout(4'd3, 0, 0, 1'b0, 10, vc, dk, fv, hc, bk);
    check("t6_p3_cleared", 32'(dk), 32'd1);
    exp_q.push_back(DONE_E);
    run_fanout(4'd0, 0, 0, 1'b0, 10, vc, dk, fv, hc, bk);
    check("t6_p0_cleared", 32'(dk), 32'd1);

    // Out-of-range writes are dropped; every entry reads back zero
    prog(3'd3, 4'd7, 7'd64, 1'b0, 4'h0);
    prog(3'd4, 4'd0, 7'd64, 1'b0, 4'h5);
    prog(3'd1, 4'd3, 7'd0,  1'b0, 4'h0);
    prog(3'd2, 4'd3, 7'd64, 1'b0, 4'h0);
    for (int i = 0; i < 64; i++) exp_q.push_back(beat(4'd0, 8'd0, (i == 63)));
    exp_q.push_back(DONE_E);
    run_fanout(4'd3, 0, 0, 1'b0, 100, vc, dk, fv, hc, bk);
    check("t6_all_beats", 32'(vc), 32'd64);
    check("t6_all_done", 32'(dk), 32'd65);

    check("zero_outside_emit", 32'(zero_viol), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
